zvc_tile_sequencer: RTL and testbench

- Sequences one tile of LIFM lines (with metadata lines) through the zero-value compressor datapath.
- Admits lines from the line buffer via a valid/ready handshake and issues one compressor capture per accepted line.
- Tracks lines in flight through the compressor's fixed-latency pipeline, emits per-line results downstream under a credit scheme, and accumulates the tile's total non-zero word count.
- Sits between the LIFM line buffer, the compressor and the compressed-line writer.

---
 rtl/zvc_tile_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_zvc_tile_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zvc_tile_sequencer.sv
// Tile sequencer for the zero-value compressor. It admits LIFM lines from the
// line buffer, issues one compressor capture per accepted line, follows each
// line through the fixed-latency compressor pipeline, and emits per-line
// non-zero counts downstream under a credit scheme. It also keeps a running
// non-zero total for the tile.
module zvc_tile_sequencer #(
   parameter int unsigned LINE_SIZE    = 32,
   parameter int unsigned CNT_WIDTH    = 6,
   parameter int unsigned PIPE_LATENCY = 2,
   parameter int unsigned NLINE_WIDTH  = 10,
   parameter int unsigned TOTAL_WIDTH  = 16,
   parameter int unsigned CREDITS      = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NLINE_WIDTH-1:0] cfg_num_lines,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   comp_en,
   input  logic [CNT_WIDTH-1:0]   comp_nz_cnt,
   output logic                   out_valid,
   output logic                   out_last,
   output logic [CNT_WIDTH-1:0]   out_nz_cnt,
   input  logic                   credit_return,
   output logic [TOTAL_WIDTH-1:0] total_nz,
   output logic                   err
);

   localparam int unsigned CRW = $clog2(CREDITS + 1);

   // Elaboration-time parameter sanity checks
   if (CNT_WIDTH < $clog2(LINE_SIZE) + 1) begin : g_bad_cnt_width
      $error("CNT_WIDTH too narrow to hold a full line count");
   end
   if (PIPE_LATENCY < 1) begin : g_bad_latency
      $error("PIPE_LATENCY must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [NLINE_WIDTH-1:0]  r_num;
   logic [NLINE_WIDTH-1:0]  r_issued;
   logic [NLINE_WIDTH-1:0]  r_retired;
   logic [CRW-1:0]          r_credits;
   logic [PIPE_LATENCY-1:0] r_vpipe;
   logic                    r_out_valid;
   logic                    r_out_last;
   logic [CNT_WIDTH-1:0]    r_out_nz;
   logic [TOTAL_WIDTH-1:0]  r_total;
   logic                    r_err;

   logic                    w_busy;
   logic                    w_done;
   logic                    w_in_ready;
   logic                    w_comp_en;
   logic                    w_start_acc;
   logic                    w_tap;
   logic                    w_issue_last;
   logic                    w_retire_last;

   // The line whose count is on comp_nz_cnt this cycle
   assign w_tap         = r_vpipe[PIPE_LATENCY-1];
   assign w_issue_last  = (r_issued  == r_num - NLINE_WIDTH'(1));
   assign w_retire_last = (r_retired == r_num - NLINE_WIDTH'(1));
   assign w_comp_en     = in_valid & w_in_ready;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and handshake/status outputs
   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_in_ready  = 1'b0;
      w_start_acc = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (start) begin
               w_start_acc = 1'b1;
               w_state_nxt = (cfg_num_lines == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            w_in_ready = (r_credits != '0) && (r_issued < r_num);
            if (in_valid && w_in_ready && w_issue_last) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_tap && w_retire_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Valid shift register mirroring the compressor pipeline
   if (PIPE_LATENCY == 1) begin : g_pipe1
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_vpipe <= '0;
         end else begin
            r_vpipe <= w_comp_en;
         end
      end
   end else begin : g_pipen
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_vpipe <= '0;
         end else begin
            r_vpipe <= {r_vpipe[PIPE_LATENCY-2:0], w_comp_en};
         end
      end
   end

   // Tile counters, accumulator and registered per-line result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_num       <= '0;
         r_issued    <= '0;
         r_retired   <= '0;
         r_total     <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_nz    <= '0;
      end else begin
         if (w_start_acc) begin
            r_num     <= cfg_num_lines;
            r_issued  <= '0;
            r_retired <= '0;
            r_total   <= '0;
         end else begin
            if (w_comp_en) begin
               r_issued <= r_issued + NLINE_WIDTH'(1);
            end
            if (w_tap) begin
               r_retired <= r_retired + NLINE_WIDTH'(1);
               r_total   <= r_total + TOTAL_WIDTH'(comp_nz_cnt);
            end
         end
         r_out_valid <= w_tap;
         r_out_last  <= w_tap & w_retire_last;
         if (w_tap) begin
            r_out_nz <= comp_nz_cnt;
         end
      end
   end

   // Downstream credit counter with sticky overflow flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_credits <= CRW'(CREDITS);
         r_err     <= 1'b0;
      end else if (w_comp_en && !credit_return) begin
         r_credits <= r_credits - CRW'(1);
      end else if (credit_return && !w_comp_en) begin
         if (r_credits == CRW'(CREDITS)) begin
            r_err <= 1'b1;
         end else begin
            r_credits <= r_credits + CRW'(1);
         end
      end
   end

   assign busy       = w_busy;
   assign done       = w_done;
   assign in_ready   = w_in_ready;
   assign comp_en    = w_comp_en;
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign out_nz_cnt = r_out_nz;
   assign total_nz   = r_total;
   assign err        = r_err;

endmodule

// File: tb/tb_zvc_tile_sequencer.sv
// Bench for zvc_tile_sequencer. A transaction-level model (line counts, a
// credit count, and a queue of expected results with due cycles) predicts
// every output each cycle; a small compressor stand-in returns each line's
// count PIPE_LATENCY cycles after its capture.
module tb_zvc_tile_sequencer;

   localparam int unsigned L     = 2;
   localparam int unsigned NCRED = 4;
   localparam int unsigned CW    = 6;

   logic          clk;
   logic          reset_n;
   logic [9:0]    cfg_num_lines;
   logic          start;
   logic          busy;
   logic          done;
   logic          in_valid;
   logic          in_ready;
   logic          comp_en;
   logic [CW-1:0] comp_nz_cnt;
   logic          out_valid;
   logic          out_last;
   logic [CW-1:0] out_nz_cnt;
   logic          credit_return;
   logic [15:0]   total_nz;
   logic          err;

   zvc_tile_sequencer #(
      .LINE_SIZE   (32),
      .CNT_WIDTH   (CW),
      .PIPE_LATENCY(L),
      .NLINE_WIDTH (10),
      .TOTAL_WIDTH (16),
      .CREDITS     (NCRED)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cfg_num_lines(cfg_num_lines),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .comp_en      (comp_en),
      .comp_nz_cnt  (comp_nz_cnt),
      .out_valid    (out_valid),
      .out_last     (out_last),
      .out_nz_cnt   (out_nz_cnt),
      .credit_return(credit_return),
      .total_nz     (total_nz),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      int unsigned val;
      logic        last;
   } item_t;

   item_t       comp_q[$];
   item_t       pend[$];
   int unsigned nz_tab[$];

   int          errors = 0;
   int          checks = 0;
   int unsigned cyc    = 0;

   bit          m_in_tile;
   int unsigned m_num;
   int unsigned m_issued;
   int unsigned m_credits;
   int unsigned m_total;
   int unsigned m_done_at;
   bit          m_err;

   bit          g_iv_mode;
   bit          g_iv;
   int unsigned g_cr_mode;
   bit          g_force_cr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_clear();
      m_in_tile = 0;
      m_num     = 0;
      m_issued  = 0;
      m_credits = NCRED;
      m_total   = 0;
      m_done_at = 32'hFFFF_FFFF;
      m_err     = 0;
      comp_q.delete();
      pend.delete();
   endtask

   task automatic do_reset();
      start    = 1'b0;
      in_valid = 1'b1;
      reset_n  = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_comp_en", comp_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_nz_cnt", out_nz_cnt, 0);
      check("rst_total_nz", total_nz, 0);
      check("rst_err", err, 0);
      model_clear();
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc += 2;
   endtask

   // One clock cycle: drive inputs, check all outputs, advance the model
   task automatic step();
      item_t       it;
      logic        exp_ov;
      logic        exp_last;
      logic        exp_ready;
      logic        exp_en;
      logic        exp_done;
      int unsigned exp_cnt;
      int unsigned v;
      exp_ov   = 1'b0;
      exp_last = 1'b0;
      exp_cnt  = 0;
      if (comp_q.size() > 0 && comp_q[0].due == cyc) begin
         it          = comp_q.pop_front();
         comp_nz_cnt = CW'(it.val);
      end else begin
         comp_nz_cnt = CW'($urandom_range(0, 63));
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
         it       = pend.pop_front();
         exp_ov   = 1'b1;
         exp_last = it.last;
         exp_cnt  = it.val;
         m_total  = (m_total + it.val) % 65536;
      end
      exp_done  = m_in_tile && (cyc == m_done_at);
      exp_ready = m_in_tile && (m_issued < m_num) && (m_credits > 0);
      in_valid  = g_iv_mode ? 1'($urandom_range(0, 1)) : g_iv;
      case (g_cr_mode)
         1:       credit_return = exp_ov;
         2:       credit_return = (m_credits < NCRED) && ($urandom_range(0, 2) == 0);
         default: credit_return = 1'b0;
      endcase
      if (g_force_cr) credit_return = 1'b1;
      exp_en = in_valid && exp_ready;
      #1;
      check("in_ready", in_ready, exp_ready);
      check("comp_en", comp_en, exp_en);
      check("out_valid", out_valid, exp_ov);
      check("out_last", out_last, exp_last);
      check("done", done, exp_done);
      check("busy", busy, m_in_tile);
      check("total_nz", total_nz, m_total);
      check("err", err, m_err);
      if (exp_ov) check("out_nz_cnt", out_nz_cnt, exp_cnt);

      if (exp_en) begin
         if (nz_tab.size() > 0) v = nz_tab.pop_front();
         else v = $urandom_range(0, 32);
         comp_q.push_back('{due: cyc + L, val: v, last: 1'b0});
         pend.push_back('{due: cyc + L + 1, val: v, last: (m_issued == m_num - 1)});
         if (m_issued == m_num - 1) m_done_at = cyc + L + 1;
         m_issued++;
      end
      if (exp_en && !credit_return) begin
         m_credits--;
      end else if (credit_return && !exp_en) begin
         if (m_credits == NCRED) m_err = 1;
         else m_credits++;
      end
      if (exp_done) begin
         m_in_tile = 0;
      end else if (!m_in_tile && start) begin
         m_in_tile = 1;
         m_num     = cfg_num_lines;
         m_issued  = 0;
         m_total   = 0;
         m_done_at = (cfg_num_lines == 0) ? cyc + 1 : 32'hFFFF_FFFF;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic start_tile(input int unsigned n);
      cfg_num_lines = 10'(n);
      start         = 1'b1;
      step();
      start         = 1'b0;
      cfg_num_lines = 10'($urandom_range(0, 1023));
   endtask

   task automatic wait_tile(input int unsigned budget);
      int unsigned n;
      n = 0;
      while (m_in_tile && n < budget) begin
         step();
         n++;
      end
      if (m_in_tile) begin
         errors++;
         checks++;
         $error("FAIL tile_timeout: observed=busy expected=done within %0d cycles", budget);
      end
      step();
   endtask

   initial begin
      int unsigned n;
      reset_n       = 1'b1;
      start         = 1'b0;
      in_valid      = 1'b0;
      credit_return = 1'b0;
      cfg_num_lines = '0;
      comp_nz_cnt   = '0;
      g_iv_mode     = 0;
      g_iv          = 0;
      g_cr_mode     = 0;
      g_force_cr    = 0;
      model_clear();
      #1;
      do_reset();
      step();
      step();

      // Three lines back to back, credits returned with each result
      nz_tab    = '{5, 0, 32};
      g_iv      = 1;
      g_cr_mode = 1;
      start_tile(3);
      wait_tile(50);
      check("t1_total", total_nz, 37);

      // Empty tile
      start_tile(0);
      wait_tile(10);
      check("t3_total", total_nz, 0);

      // Start during RUN is ignored
      start_tile(3);
      step();
      cfg_num_lines = 10'd9;
      start         = 1'b1;
      step();
      start         = 1'b0;
      wait_tile(50);

      // Credit exhaustion, then two returns release the last two lines
      g_cr_mode = 0;
      start_tile(6);
      repeat (8) step();
      check("t2_stalled_issued", m_issued, 4);
      g_force_cr = 1; step(); g_force_cr = 0;
      step();
      step();
      g_force_cr = 1; step(); g_force_cr = 0;
      wait_tile(50);
      g_iv = 0;
      repeat (4) begin g_force_cr = 1; step(); end
      g_force_cr = 0;

      // Simultaneous issue and return at credits=2
      g_iv = 1;
      start_tile(4);
      step();
      step();
      g_force_cr = 1; step(); g_force_cr = 0;
      wait_tile(50);
      g_iv = 0;
      repeat (3) begin g_force_cr = 1; step(); end
      // Return with all credits home sets the sticky error
      step();
      step();
      g_force_cr = 0;
      step();
      check("t4_err_set", err, 1);
      g_iv      = 1;
      g_cr_mode = 1;
      start_tile(2);
      wait_tile(50);
      check("t4_err_sticky", err, 1);

      // Reset in the middle of a tile
      start_tile(5);
      n = 0;
      while (m_issued < 2 && n < 20) begin step(); n++; end
      do_reset();
      repeat (6) step();
      start_tile(1);
      wait_tile(20);

      // Randomised tiles
      g_iv_mode = 1;
      g_cr_mode = 2;
      repeat (6) begin
         start_tile($urandom_range(1, 12));
         wait_tile(400);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
